pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The parameter list SHALL contain COUNTER_BITS, default 32, the width of all period, duty and limit values.
REQ-002 The port clk SHALL be an input of 1 bit and the single clock; all flops are rising-edge.
REQ-003 The port reset SHALL be an input of 1 bit, asynchronous and active-high.
REQ-004 The port pwm_in SHALL be an input of 1 bit carrying the asynchronous PWM waveform to measure.
REQ-005 The port timeout_limit SHALL be an input of COUNTER_BITS width giving the maximum clocks without an edge; 0 disables the timeout.
REQ-006 The port cycle SHALL be an output of COUNTER_BITS width holding the last measured period in clk cycles (rise to rise).
REQ-007 The port duty SHALL be an output of COUNTER_BITS width holding the last measured high time in clk cycles (rise to fall).
REQ-008 The port valid SHALL be an output of 1 bit that pulses for one cycle when cycle/duty update.
REQ-009 The port timeout SHALL be an output of 1 bit that is a sticky level flagging loss of signal.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer plus 1 history flop; rise/fall events fire 3 clk edges after a pin change that meets setup.
REQ-011 The FSM SHALL have the states ACQUIRE, ARMED, HIGH and LOW.
REQ-012 In ACQUIRE, a fall event SHALL move the FSM to ARMED; all other events are ignored, so a fake rise at reset release never starts a measurement.
REQ-013 In ARMED, a rise event SHALL move the FSM to HIGH and load cnt to 1.
REQ-014 In HIGH, a fall event SHALL latch high_cnt <= cnt and move the FSM to LOW.
REQ-015 In LOW, a rise event SHALL load cycle <= cnt and duty <= high_cnt, assert valid the next cycle, clear timeout, load cnt to 1 and move the FSM to HIGH.
REQ-016 cnt SHALL increment by 1 every cycle outside ACQUIRE and saturate at all-ones with no wrap; a saturated period is reported as all-ones.
REQ-017 For a steady waveform of P clocks period and H clocks high, the block SHALL report cycle=P and duty=H exactly.
REQ-018 The first valid SHALL occur on the second rise after the first fall seen in ACQUIRE; no partial period is ever reported.
REQ-019 In ARMED, HIGH or LOW, with timeout_limit != 0 and cnt >= timeout_limit, the next cycle SHALL set timeout=1, cycle=0, duty=0, cnt=0 and state ACQUIRE, with no valid pulse.
REQ-020 When an edge event and the timeout condition fall in the same cycle, the timeout SHALL take priority and the edge is discarded.
REQ-021 cycle and duty SHALL hold their values between valid pulses.
REQ-022 The minimum resolvable high or low phase SHALL be 1 clk of synchronized signal; shorter pin glitches may be missed without error.

Reset
REQ-023 While reset is high, the block SHALL hold the state at ACQUIRE and the sync/history flops, cnt, high_cnt, cycle, duty, valid and timeout all at 0.
REQ-024 A reset asserted mid-measurement SHALL abort the measurement immediately, with no valid pulse and no change beyond the reset values.

Structure
REQ-025 The package pwm_pkg SHALL hold the FSM state enum (ACQUIRE, ARMED, HIGH, LOW) and the default COUNTER_BITS constant.
REQ-026 Synchronization and edge detection SHALL live in the sub-module sync_edge_detect (outputs rise and fall pulses); the FSM and counters stay in pwm_capture.

Verification
REQ-027 The bench SHALL drive P=100, H=25, limit=0 -> after the 2nd rise, valid pulses every 100 clks with cycle=100 and duty=25.
REQ-028 The bench SHALL hold the pin low with limit=500 after lock at P=100 -> timeout=1 and cycle=duty=0 once 500 clks pass without an edge; reapplying the waveform gives the next valid and timeout=0.
REQ-029 The bench SHALL change duty from H=25 to H=75 at a rise with P=100 -> the next valid reports duty=75 and cycle=100, with no intermediate value.
REQ-030 The bench SHALL use COUNTER_BITS=8, limit=0, P=300, H=10 -> cycle=255 (saturated) and duty=10.
REQ-031 The bench SHALL assert reset for 3 clks while in LOW with the pin held high across the release -> no valid; the first valid comes only after a fall, rise, fall and rise sequence.
REQ-032 The bench SHALL drive P=4, H=1, synchronous to clk -> cycle=4 and duty=1 every period.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM period/duty capture block.
package pwm_pkg;

    localparam int COUNTER_BITS_DEFAULT = 32;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        ARMED   = 2'd1,
        HIGH    = 2'd2,
        LOW     = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for the PWM pin plus a history flop that turns
// level changes into single-cycle rise/fall pulses.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;
    assign fall = ~sync2 & hist;

endmodule

// File: rtl/pwm_capture.sv
// Measures period (rise to rise) and high time (rise to fall) of an
// asynchronous PWM input, with a sticky loss-of-signal timeout.
//
// state   | meaning
// ACQUIRE | waiting for a first fall; rises ignored so no partial period
// ARMED   | fall seen, waiting for the rise that starts a measurement
// HIGH    | measuring high phase, cnt counts from the rise
// LOW     | high time latched, waiting for the rise that closes the period
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int COUNTER_BITS = COUNTER_BITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pwm_in,
    input  logic [COUNTER_BITS-1:0] timeout_limit,
    output logic [COUNTER_BITS-1:0] cycle,
    output logic [COUNTER_BITS-1:0] duty,
    output logic                    valid,
    output logic                    timeout
);

    localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;

    state_t                  state;
    state_t                  state_next;
    logic                    rise;
    logic                    fall;
    logic [COUNTER_BITS-1:0] cnt;
    logic [COUNTER_BITS-1:0] high_cnt;
    logic                    timeout_hit;
    logic                    start_cnt;
    logic                    latch_high;
    logic                    capture;

    sync_edge_detect u_sync (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .rise   (rise),
        .fall   (fall)
    );

    // Timeout outranks any edge arriving in the same cycle.
    assign timeout_hit = (state != ACQUIRE) && (timeout_limit != '0) &&
                         (cnt >= timeout_limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACQUIRE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACQUIRE: if (fall) state_next = ARMED;
            ARMED: begin
                if (timeout_hit)  state_next = ACQUIRE;
                else if (rise)    state_next = HIGH;
            end
            HIGH: begin
                if (timeout_hit)  state_next = ACQUIRE;
                else if (fall)    state_next = LOW;
            end
            LOW: begin
                if (timeout_hit)  state_next = ACQUIRE;
                else if (rise)    state_next = HIGH;
            end
            default: state_next = ACQUIRE;
        endcase
    end

    always_comb begin
        start_cnt  = 1'b0;
        latch_high = 1'b0;
        capture    = 1'b0;
        if (!timeout_hit) begin
            case (state)
                ARMED: start_cnt = rise;
                HIGH:  latch_high = fall;
                LOW: begin
                    start_cnt = rise;
                    capture   = rise;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            high_cnt <= '0;
            cycle    <= '0;
            duty     <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (timeout_hit) begin
                timeout <= 1'b1;
                cycle   <= '0;
                duty    <= '0;
                cnt     <= '0;
            end else begin
                if (capture) begin
                    cycle   <= cnt;
                    duty    <= high_cnt;
                    valid   <= 1'b1;
                    timeout <= 1'b0;
                end
                if (latch_high) begin
                    high_cnt <= cnt;
                end
                if (start_cnt) begin
                    cnt <= {{(COUNTER_BITS-1){1'b0}}, 1'b1};
                end else if (state != ACQUIRE && cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected cycle/duty
// pairs, a monitor pops and compares them on every valid pulse.
module tb_pwm_capture;
    import pwm_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pwm_in = 1'b0;
    logic [31:0] timeout_limit = '0;
    logic [31:0] cycle;
    logic [31:0] duty;
    logic        valid;
    logic        timeout;

    logic        pwm8 = 1'b0;
    logic [7:0]  limit8 = '0;
    logic [7:0]  cycle8;
    logic [7:0]  duty8;
    logic        valid8;
    logic        timeout8;

    int checks = 0;
    int errors = 0;
    logic [63:0] q[$];
    logic [15:0] q8[$];

    always #5 clk = ~clk;

    pwm_capture #(.COUNTER_BITS(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .pwm_in        (pwm_in),
        .timeout_limit (timeout_limit),
        .cycle         (cycle),
        .duty          (duty),
        .valid         (valid),
        .timeout       (timeout)
    );

    pwm_capture #(.COUNTER_BITS(8)) dut8 (
        .clk           (clk),
        .reset         (reset),
        .pwm_in        (pwm8),
        .timeout_limit (limit8),
        .cycle         (cycle8),
        .duty          (duty8),
        .valid         (valid8),
        .timeout       (timeout8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_n(input int c, input int d, input int n);
        for (int i = 0; i < n; i++) q.push_back({c[31:0], d[31:0]});
    endtask

    task automatic drive(input int p, input int h);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic drive8(input int p, input int h);
        pwm8 = 1'b1;
        repeat (h) @(negedge clk);
        pwm8 = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid cycle %0d duty %0d at %0t", cycle, duty, $time);
            end else begin
                e = q.pop_front();
                check("cycle", cycle, e[63:32]);
                check("duty", duty, e[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (valid8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid8 cycle %0d duty %0d at %0t", cycle8, duty8, $time);
            end else begin
                e = q8.pop_front();
                check("cycle8", {24'd0, cycle8}, {24'd0, e[15:8]});
                check("duty8", {24'd0, duty8}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_cycle", cycle, 0);
        check("reset_duty", duty, 0);
        check("reset_valid", {31'd0, valid}, 0);
        check("reset_timeout", {31'd0, timeout}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Lock at P=100 H=25: valids from the 3rd rise on.
        expect_n(100, 25, 3);
        repeat (5) drive(100, 25);
        check("no_timeout_limit0", {31'd0, timeout}, 0);

        // Duty change at a rise: old period reported once, then 75.
        expect_n(100, 25, 1);
        expect_n(100, 75, 2);
        repeat (3) drive(100, 75);

        // Loss of signal with limit 500.
        timeout_limit = 32'd500;
        repeat (350) @(negedge clk);
        check("timeout_early", {31'd0, timeout}, 0);
        repeat (250) @(negedge clk);
        check("timeout_set", {31'd0, timeout}, 1);
        check("timeout_cycle", cycle, 0);
        check("timeout_duty", duty, 0);

        // Recovery: reacquire, two valids, timeout cleared.
        expect_n(100, 25, 2);
        repeat (4) drive(100, 25);
        check("timeout_cleared", {31'd0, timeout}, 0);
        check("recover_cycle", cycle, 100);
        check("recover_duty", duty, 25);

        // Reset in LOW with the pin high across release.
        reset = 1'b1;
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_cycle", cycle, 0);
        check("midreset_duty", duty, 0);
        check("midreset_valid", {31'd0, valid}, 0);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        pwm_in = 1'b0;
        repeat (75) @(negedge clk);
        check("post_reset_cycle", cycle, 0);
        expect_n(100, 25, 2);
        repeat (3) drive(100, 25);

        // Minimum phases, P=4 H=1.
        expect_n(100, 25, 1);
        expect_n(4, 1, 5);
        repeat (6) drive(4, 1);
        repeat (20) @(negedge clk);

        // 8-bit counter saturates on a 300-clock period.
        q8.push_back({8'd255, 8'd10});
        q8.push_back({8'd255, 8'd10});
        repeat (4) drive8(300, 10);

        for (int i = 0; i < 200 && (q.size() != 0 || q8.size() != 0); i++) @(negedge clk);
        check("pending_expected", q.size(), 0);
        check("pending_expected8", q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
